// File: rtl/tqvp_bus_pkg.sv
// Shared encodings for the TinyQV peripheral-bus initiator: transfer sizes,
// response status codes, FSM state values and the read-data size mask.
package tqvp_bus_pkg;

    localparam logic [1:0] SZ_8    = 2'b00;
    localparam logic [1:0] SZ_16   = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;
    localparam logic [1:0] SZ_IDLE = 2'b11;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BADSIZE = 2'b10;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t S_IDLE = 2'b00;
    localparam bus_state_t S_REQ  = 2'b01;
    localparam bus_state_t S_RSP  = 2'b10;

    // Byte-lane mask for a transfer size; the idle/illegal encoding selects nothing.
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        logic [31:0] m;
        case (size)
            SZ_8:    m = 32'h0000_00FF;
            SZ_16:   m = 32'h0000_FFFF;
            SZ_32:   m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tqvp_rdata_align.sv
// Zero-extends peripheral read data to the transfer size; shared with the
// peripheral-side read mux.
module tqvp_rdata_align
    import tqvp_bus_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [31:0] i_data,
    output logic [31:0] o_data
);

    // Keep only the lanes covered by the transfer size.
    always_comb begin
        o_data = i_data & size_mask(i_size);
    end

endmodule

// File: rtl/tqvp_bus_initiator.sv
// TinyQV peripheral-bus initiator: one outstanding command, registered bus
// strobes, wait-for-data_ready with timeout, size-masked read response.
module tqvp_bus_initiator
    import tqvp_bus_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_size,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_status,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data_in,
    output logic [1:0]        data_write_n,
    output logic [1:0]        data_read_n,
    input  logic [31:0]       data_out,
    input  logic              data_ready,
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    bus_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_write;
    logic [1:0]         r_size;
    logic [ADDR_W-1:0]  r_address;
    logic [31:0]        r_data_in;
    logic [1:0]         r_write_n;
    logic [1:0]         r_read_n;
    logic               r_rsp_valid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_status;
    logic               r_cmd_ready;
    logic               r_busy;

    bus_state_t         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_is_write_nxt;
    logic [1:0]         w_size_nxt;
    logic [ADDR_W-1:0]  w_address_nxt;
    logic [31:0]        w_data_in_nxt;
    logic [1:0]         w_write_n_nxt;
    logic [1:0]         w_read_n_nxt;
    logic               w_rsp_valid_nxt;
    logic [31:0]        w_rdata_nxt;
    logic [1:0]         w_status_nxt;
    logic [31:0]        w_aligned;

    tqvp_rdata_align u_align (
        .i_size (r_size),
        .i_data (data_out),
        .o_data (w_aligned)
    );

    // Next-state and next-output decode for the IDLE/REQ/RSP machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_write_nxt  = r_is_write;
        w_size_nxt      = r_size;
        w_address_nxt   = r_address;
        w_data_in_nxt   = r_data_in;
        w_write_n_nxt   = r_write_n;
        w_read_n_nxt    = r_read_n;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rdata_nxt     = r_rdata;
        w_status_nxt    = r_status;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    if (cmd_size == SZ_IDLE) begin
                        // Illegal size never reaches the bus.
                        w_state_nxt     = S_RSP;
                        w_rsp_valid_nxt = 1'b1;
                        w_status_nxt    = ST_BADSIZE;
                        w_rdata_nxt     = 32'h0000_0000;
                    end else begin
                        w_state_nxt    = S_REQ;
                        w_cnt_nxt      = '0;
                        w_is_write_nxt = cmd_write;
                        w_size_nxt     = cmd_size;
                        w_address_nxt  = cmd_addr;
                        w_data_in_nxt  = cmd_wdata;
                        w_write_n_nxt  = cmd_write ? cmd_size : SZ_IDLE;
                        w_read_n_nxt   = cmd_write ? SZ_IDLE : cmd_size;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (data_ready) begin
                    w_state_nxt     = S_RSP;
                    w_write_n_nxt   = SZ_IDLE;
                    w_read_n_nxt    = SZ_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_status_nxt    = ST_OK;
                    w_rdata_nxt     = r_is_write ? 32'h0000_0000 : w_aligned;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = S_RSP;
                    w_write_n_nxt   = SZ_IDLE;
                    w_read_n_nxt    = SZ_IDLE;
                    w_rsp_valid_nxt = 1'b1;
                    w_status_nxt    = ST_TIMEOUT;
                    w_rdata_nxt     = 32'h0000_0000;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RSP;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_write_n_nxt   = SZ_IDLE;
                w_read_n_nxt    = SZ_IDLE;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_write  <= 1'b0;
            r_size      <= SZ_IDLE;
            r_address   <= '0;
            r_data_in   <= 32'h0000_0000;
            r_write_n   <= SZ_IDLE;
            r_read_n    <= SZ_IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'h0000_0000;
            r_status    <= ST_OK;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_write  <= w_is_write_nxt;
            r_size      <= w_size_nxt;
            r_address   <= w_address_nxt;
            r_data_in   <= w_data_in_nxt;
            r_write_n   <= w_write_n_nxt;
            r_read_n    <= w_read_n_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_status    <= w_status_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rdata;
    assign rsp_status   = r_status;
    assign address      = r_address;
    assign data_in      = r_data_in;
    assign data_write_n = r_write_n;
    assign data_read_n  = r_read_n;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Scoreboard bench for tqvp_bus_initiator with a scripted peripheral (TIMEOUT=4).
module tb_tqvp_bus_initiator;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'b00;
    logic [5:0]  cmd_addr = 6'd0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out = 32'h0;
    logic        data_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [33:0] sb_q[$];

    tqvp_bus_initiator #(.TIMEOUT(TO), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_status(rsp_status), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // wait_n: cycle index at which data_ready is raised (-1 = never); bp: rsp_ready hold-off cycles
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [5:0] addr,
                          input logic [31:0] wd, input int wait_n, input logic [31:0] pdata,
                          input int bp);
        logic [1:0]  e_st;
        logic [31:0] e_rd;
        logic [31:0] mask;
        logic [33:0] item;
        logic [1:0]  e_w, e_r;
        int          e_cyc, n_strobe;
        logic        bad;
        case (sz)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        if (sz == 2'b11) begin
            e_st = 2'b10; e_rd = 32'h0; e_cyc = 0;
        end else if (wait_n < 0 || wait_n >= TO) begin
            e_st = 2'b01; e_rd = 32'h0; e_cyc = TO;
        end else begin
            e_st = 2'b00; e_rd = wr ? 32'h0 : (pdata & mask); e_cyc = wait_n + 1;
        end
        sb_q.push_back({e_st, e_rd});
        e_w = wr ? sz : 2'b11;
        e_r = wr ? 2'b11 : sz;

        check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_size = sz; cmd_addr = addr; cmd_wdata = wd;
        step();
        cmd_valid = 1'b0;
        check("busy_after_accept", {31'h0, busy}, 32'h1);

        n_strobe = 0;
        bad = 1'b0;
        for (int c = 0; c < TO + 3 && !rsp_valid; c++) begin
            if (data_write_n != 2'b11 || data_read_n != 2'b11) begin
                n_strobe++;
                if (data_write_n != e_w || data_read_n != e_r || address != addr) bad = 1'b1;
                if (wr && data_in != wd) bad = 1'b1;
            end
            data_ready = (c == wait_n);
            data_out   = (c == wait_n) ? pdata : $urandom;
            step();
            data_ready = 1'b0;
        end
        if (sz == 2'b11 && (data_write_n != 2'b11 || data_read_n != 2'b11)) bad = 1'b1;
        check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("strobe_cycles", n_strobe, e_cyc);
        check("strobe_values", {31'h0, bad}, 32'h0);
        check("strobes_idle", {28'h0, data_write_n, data_read_n}, 32'hF);

        for (int b = 0; b < bp; b++) begin
            check("bp_hold", {cmd_ready, rsp_valid, rsp_status, rsp_rdata[27:0]},
                  {1'b0, 1'b1, e_st, e_rd[27:0]});
            step();
        end

        rsp_ready = 1'b1;
        if (rsp_valid && sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check("rsp_status", {30'h0, rsp_status}, {30'h0, item[33:32]});
            check("rsp_rdata", rsp_rdata, item[31:0]);
        end else begin
            check("rsp_present", {31'h0, rsp_valid}, 32'h1);
        end
        step();
        rsp_ready = 1'b0;
        check("rsp_done", {30'h0, rsp_valid, cmd_ready}, 32'h1);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("reset_async", {cmd_ready, rsp_valid, busy, rsp_status, data_write_n, data_read_n},
              {1'b1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11});
        step();
        step();
        check("reset_data", rsp_rdata | data_in | {26'h0, address}, 32'h0);
        rst = 1'b0;
        step();

        do_txn(1'b1, 2'b10, 6'h00, 32'hA000_0003, 0, 32'h0, 0);
        do_txn(1'b0, 2'b00, 6'h18, 32'h0, 3, 32'h1234_5678, 0);
        do_txn(1'b0, 2'b10, 6'h04, 32'h0, -1, 32'h0, 0);
        do_txn(1'b0, 2'b10, 6'h05, 32'h0, TO - 1, 32'hCAFE_F00D, 0);
        do_txn(1'b0, 2'b11, 6'h06, 32'h0, 0, 32'h0, 0);
        do_txn(1'b0, 2'b01, 6'h07, 32'h0, 1, 32'hBEEF_CAFE, 5);
        do_txn(1'b1, 2'b00, 6'h3F, 32'h5555_00AA, -1, 32'h0, 1);

        data_ready = 1'b1;
        step();
        step();
        data_ready = 1'b0;
        check("idle_ignores_ready", {30'h0, busy, rsp_valid}, 32'h0);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 2'b10; cmd_addr = 6'h11;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_req_strobe", {30'h0, data_read_n}, 32'h2);
        #2 rst = 1'b1;
        #1;
        check("mid_req_reset", {cmd_ready, rsp_valid, busy, data_write_n, data_read_n},
              {1'b1, 1'b0, 1'b0, 2'b11, 2'b11});
        step();
        rst = 1'b0;
        step();
        do_txn(1'b0, 2'b01, 6'h22, 32'h0, 2, 32'h8765_4321, 0);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
